// File: rtl/mod_reduce_pkg.sv
// -----------------------------------------------------------------------------
// mod_reduce_pkg
// Shared definitions for the multiplier-family sequential blocks:
//   - state_t   : IDLE / ITER / DONE control-state encoding
//   - cnt_width : width of the step counter for a given operand width,
//                 $clog2(2*dw)+1, wide enough to hold 2*dw itself
// -----------------------------------------------------------------------------
package mod_reduce_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int cnt_width(input int dw);
      return $clog2(2 * dw) + 1;
   endfunction

endpackage

// File: rtl/mod_reduce_if.sv
// -----------------------------------------------------------------------------
// mod_reduce_if
// Level-held op_enable / op_finish handshake plus operand and result buses.
//   master : drives op_enable, in_dividend, in_modulus; observes the results
//   slave  : the reducer; drives out_quotient, out_remainder, div_by_zero,
//            op_finish
// -----------------------------------------------------------------------------
interface mod_reduce_if #(
   parameter int DATA_WIDTH = 32
);
   import mod_reduce_pkg::*;

   logic                      op_enable;
   logic [2*DATA_WIDTH-1:0]   in_dividend;
   logic [DATA_WIDTH-1:0]     in_modulus;
   logic [2*DATA_WIDTH-1:0]   out_quotient;
   logic [DATA_WIDTH-1:0]     out_remainder;
   logic                      div_by_zero;
   logic                      op_finish;

   modport master (
      output op_enable, in_dividend, in_modulus,
      input  out_quotient, out_remainder, div_by_zero, op_finish
   );

   modport slave (
      input  op_enable, in_dividend, in_modulus,
      output out_quotient, out_remainder, div_by_zero, op_finish
   );

endinterface

// File: rtl/mod_reduce_cond_sub.sv
// -----------------------------------------------------------------------------
// cond_sub
// Ripple-borrow subtractor a - b with a result mux: returns a - b when a >= b
// (no borrow out), otherwise returns a unchanged.
//   i_a, i_b  : WIDTH-bit unsigned operands
//   o_result  : conditionally reduced value
//   o_borrow  : 1 when a < b
// -----------------------------------------------------------------------------
module cond_sub #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_result,
   output logic             o_borrow
);

   logic [WIDTH:0]   w_bc;
   logic [WIDTH-1:0] w_diff;

   assign w_bc[0] = 1'b0;

   genvar gi;
   for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign w_diff[gi]   = i_a[gi] ^ i_b[gi] ^ w_bc[gi];
      assign w_bc[gi + 1] = (~i_a[gi] & i_b[gi]) | (~(i_a[gi] ^ i_b[gi]) & w_bc[gi]);
   end

   // The borrow-out doubles as the a < b comparison.
   assign o_borrow = w_bc[WIDTH];
   assign o_result = o_borrow ? i_a : w_diff;

endmodule

// File: rtl/mod_reduce.sv
// -----------------------------------------------------------------------------
// mod_reduce
// Sequential restoring divider: reduces a 2*DATA_WIDTH dividend by a
// DATA_WIDTH modulus, one quotient bit per clock.
//   i_clk   : clock, all logic on posedge
//   i_rst_n : synchronous active-low reset
//   bus     : mod_reduce_if.slave (op_enable, in_dividend, in_modulus in;
//             out_quotient, out_remainder, div_by_zero, op_finish out)
// A zero modulus finishes in one edge with quotient all ones, remainder =
// low half of the dividend and div_by_zero set. Dropping op_enable aborts
// or releases the result and clears every output on the next edge.
// -----------------------------------------------------------------------------
module mod_reduce
   import mod_reduce_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   mod_reduce_if.slave  bus
);

   localparam int DW2   = 2 * DATA_WIDTH;
   localparam int CNT_W = cnt_width(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DW2 - 1);

   state_t                  r_state,  w_state_nxt;
   logic [DW2-1:0]          r_d,      w_d_nxt;
   logic [DATA_WIDTH-1:0]   r_m,      w_m_nxt;
   logic [DATA_WIDTH:0]     r_r,      w_r_nxt;
   logic [DW2-1:0]          r_q,      w_q_nxt;
   logic [CNT_W-1:0]        r_cnt,    w_cnt_nxt;
   logic [DW2-1:0]          r_quot,   w_quot_nxt;
   logic [DATA_WIDTH-1:0]   r_rem,    w_rem_nxt;
   logic                    r_dbz,    w_dbz_nxt;
   logic                    r_fin,    w_fin_nxt;

   logic                    w_clear;
   logic [DATA_WIDTH:0]     w_r_shift;
   logic [DATA_WIDTH:0]     w_sub_res;
   logic                    w_borrow;
   logic [DW2-1:0]          w_q_step;

   // R stays below M between steps, so the top bit of R is always 0 and the
   // shifted value {R, D[MSB]} fits in DATA_WIDTH+1 bits.
   assign w_r_shift = (DATA_WIDTH + 1)'({r_r, r_d[DW2-1]});

   cond_sub #(
      .WIDTH (DATA_WIDTH + 1)
   ) u_cond_sub (
      .i_a      (w_r_shift),
      .i_b      ({1'b0, r_m}),
      .o_result (w_sub_res),
      .o_borrow (w_borrow)
   );

   assign w_q_step = {r_q[DW2-2:0], ~w_borrow};

   // Next-state and next-datapath decode for the IDLE/ITER/DONE sequencer.
   always_comb begin
      w_state_nxt = r_state;
      w_d_nxt     = r_d;
      w_m_nxt     = r_m;
      w_r_nxt     = r_r;
      w_q_nxt     = r_q;
      w_cnt_nxt   = r_cnt;
      w_quot_nxt  = r_quot;
      w_rem_nxt   = r_rem;
      w_dbz_nxt   = r_dbz;
      w_fin_nxt   = r_fin;
      w_clear     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (bus.op_enable && (bus.in_modulus == '0)) begin
               w_state_nxt = ST_DONE;
               w_quot_nxt  = '1;
               w_rem_nxt   = bus.in_dividend[DATA_WIDTH-1:0];
               w_dbz_nxt   = 1'b1;
               w_fin_nxt   = 1'b1;
            end else if (bus.op_enable) begin
               w_state_nxt = ST_ITER;
               w_d_nxt     = bus.in_dividend;
               w_m_nxt     = bus.in_modulus;
               w_r_nxt     = '0;
               w_q_nxt     = '0;
               w_cnt_nxt   = '0;
            end else begin
               w_clear = 1'b1;
            end
         end
         ST_ITER: begin
            if (!bus.op_enable) begin
               w_clear = 1'b1;
            end else begin
               w_d_nxt   = {r_d[DW2-2:0], 1'b0};
               w_r_nxt   = w_sub_res;
               w_q_nxt   = w_q_step;
               w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
               if (r_cnt == LAST_CNT) begin
                  w_state_nxt = ST_DONE;
                  w_quot_nxt  = w_q_step;
                  w_rem_nxt   = w_sub_res[DATA_WIDTH-1:0];
                  w_fin_nxt   = 1'b1;
               end else begin
                  w_state_nxt = ST_ITER;
               end
            end
         end
         ST_DONE: begin
            if (!bus.op_enable) begin
               w_clear = 1'b1;
            end else begin
               w_state_nxt = ST_DONE;
            end
         end
         default: begin
            w_clear = 1'b1;
         end
      endcase

      // Abort, release and illegal-state recovery all land in a clean IDLE.
      if (w_clear) begin
         w_state_nxt = ST_IDLE;
         w_d_nxt     = '0;
         w_m_nxt     = '0;
         w_r_nxt     = '0;
         w_q_nxt     = '0;
         w_cnt_nxt   = '0;
         w_quot_nxt  = '0;
         w_rem_nxt   = '0;
         w_dbz_nxt   = 1'b0;
         w_fin_nxt   = 1'b0;
      end else begin
         w_state_nxt = w_state_nxt;
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_d     <= '0;
         r_m     <= '0;
         r_r     <= '0;
         r_q     <= '0;
         r_cnt   <= '0;
         r_quot  <= '0;
         r_rem   <= '0;
         r_dbz   <= 1'b0;
         r_fin   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_d     <= w_d_nxt;
         r_m     <= w_m_nxt;
         r_r     <= w_r_nxt;
         r_q     <= w_q_nxt;
         r_cnt   <= w_cnt_nxt;
         r_quot  <= w_quot_nxt;
         r_rem   <= w_rem_nxt;
         r_dbz   <= w_dbz_nxt;
         r_fin   <= w_fin_nxt;
      end
   end

   assign bus.out_quotient  = r_quot;
   assign bus.out_remainder = r_rem;
   assign bus.div_by_zero   = r_dbz;
   assign bus.op_finish     = r_fin;

endmodule

// File: tb/tb_mod_reduce.sv
// -----------------------------------------------------------------------------
// tb_mod_reduce
// Directed and random checks of mod_reduce at DATA_WIDTH=4 against a plain
// arithmetic reference (/ and %), including latency, result hold, release,
// abort, mid-operation reset and divide-by-zero.
// -----------------------------------------------------------------------------
module tb_mod_reduce;

   localparam int DW = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   mod_reduce_if #(.DATA_WIDTH(DW)) bus ();

   mod_reduce #(.DATA_WIDTH(DW)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check(tag, {48'd0, bus.out_quotient, 4'd0, bus.out_remainder, 3'd0, bus.div_by_zero, 3'd0, bus.op_finish},
            64'd0);
   endtask

   // Runs one complete operation: start, wait for op_finish, check the
   // result, check it holds, then release and check the outputs clear.
   task automatic run_op(input logic [7:0] dvd, input logic [3:0] m, input string tag);
      logic [7:0] eq;
      logic [3:0] er;
      logic       edbz;
      int         lat;
      int         n;
      if (m == 4'd0) begin
         eq   = 8'hFF;
         er   = dvd[3:0];
         edbz = 1'b1;
         lat  = 1;
      end else begin
         eq   = dvd / {4'd0, m};
         er   = 4'(dvd % {4'd0, m});
         edbz = 1'b0;
         lat  = 2 * DW + 1;
      end
      bus.in_dividend = dvd;
      bus.in_modulus  = m;
      bus.op_enable   = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
         if (n == 1) begin
            // Inputs after the latch edge must not matter.
            bus.in_dividend = 8'($urandom);
            bus.in_modulus  = 4'($urandom);
         end
      end while (!bus.op_finish && n < 40);
      check({tag, "_latency"}, 64'(n), 64'(lat));
      check({tag, "_quotient"}, 64'(bus.out_quotient), 64'(eq));
      check({tag, "_remainder"}, 64'(bus.out_remainder), 64'(er));
      check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(edbz));
      tick();
      tick();
      check({tag, "_hold"}, 64'({bus.out_quotient, bus.out_remainder, bus.div_by_zero, bus.op_finish}),
            64'({eq, er, edbz, 1'b1}));
      bus.op_enable = 1'b0;
      tick();
      check_idle({tag, "_release"});
   endtask

   initial begin
      logic       seen_fin;
      logic [7:0] rd;
      logic [3:0] rm;

      bus.op_enable   = 1'b0;
      bus.in_dividend = 8'd0;
      bus.in_modulus  = 4'd0;

      // Reset state
      tick();
      tick();
      check_idle("reset");
      rst_n = 1'b1;
      tick();
      check_idle("idle_after_reset");

      // Basic and extreme reductions
      run_op(8'hA5, 4'h7, "basic");
      run_op(8'hE1, 4'hF, "e1_f");
      run_op(8'hFF, 4'h1, "ff_1");
      run_op(8'h00, 4'hF, "zero_dvd");
      run_op(8'hFF, 4'hF, "ff_f");

      // Divide by zero
      run_op(8'h3C, 4'h0, "div0");

      // Abort: op_enable low sampled at edge 4
      bus.in_dividend = 8'hA5;
      bus.in_modulus  = 4'h7;
      bus.op_enable   = 1'b1;
      tick();
      tick();
      tick();
      bus.op_enable = 1'b0;
      tick();
      check_idle("abort");
      seen_fin = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         seen_fin = seen_fin | bus.op_finish;
      end
      check("abort_no_finish", 64'(seen_fin), 64'd0);
      run_op(8'h8F, 4'h7, "restart");

      // Reset mid-operation (low at edge 5, op_enable still high)
      bus.in_dividend = 8'hA5;
      bus.in_modulus  = 4'h7;
      bus.op_enable   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
      end
      rst_n = 1'b0;
      tick();
      check_idle("mid_reset");
      rst_n = 1'b1;
      run_op(8'h8F, 4'h7, "after_reset");

      // Chained behind a multiplier: 13 x 11 reduced mod 7
      rd = 8'(13 * 11);
      run_op(rd, 4'h7, "chained");

      // Random operations, roughly one in eight with a zero modulus
      for (int i = 0; i < 40; i++) begin
         rd = 8'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            rm = 4'd0;
         end else begin
            rm = 4'($urandom_range(1, 15));
         end
         run_op(rd, rm, "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
